// File: rtl/rx_discard_mvb_merge.sv
// Merges per-channel RX discard MVB streams into one channel-tagged MVB stream.
// Each channel has a word FIFO. Each channel also has saturating discard and drop counters.
module rx_discard_mvb_merge #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned REGIONS    = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CHANNELS*REGIONS-1:0]  RX_MVB_DATA,
  input  logic [CHANNELS*REGIONS-1:0]  RX_MVB_VLD,
  input  logic [CHANNELS-1:0]          RX_MVB_SRC_RDY,
  output logic [REGIONS-1:0]           TX_MVB_DATA,
  output logic [REGIONS-1:0]           TX_MVB_VLD,
  output logic [CH_W-1:0]              TX_MVB_CHANNEL,
  output logic                         TX_MVB_SRC_RDY,
  input  logic                         TX_MVB_DST_RDY,
  input  logic [CH_W-1:0]              CNT_SEL,
  input  logic                         CNT_CLR,
  output logic [CNT_WIDTH-1:0]         CNT_DISCARDED,
  output logic [CNT_WIDTH-1:0]         CNT_DROPPED
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = 2 * REGIONS;
  localparam int unsigned PW = $clog2(REGIONS + 1);

  // Stored word layout: {vld, data}
  logic [WW-1:0]        mem_q    [CHANNELS][FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q [CHANNELS];
  logic [AW:0]          rd_ptr_q [CHANNELS];
  logic [CNT_WIDTH-1:0] disc_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] disc_d   [CHANNELS];
  logic [CNT_WIDTH-1:0] drop_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] drop_d   [CHANNELS];

  logic [CHANNELS-1:0] empty, full, cand, push, pop, clr;
  logic [CH_W-1:0]     rr_q, rr_d, pick, chan_q, chan_d;
  logic                found, out_empty;
  logic                src_rdy_q, src_rdy_d;
  logic [REGIONS-1:0]  data_q, data_d, vld_q, vld_d;

  always_comb begin : flags
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                 (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      cand[c]  = RX_MVB_SRC_RDY[c] && (|RX_MVB_VLD[c*REGIONS +: REGIONS]);
      clr[c]   = CNT_CLR && (CNT_SEL == CH_W'(c));
    end
  end

  always_comb begin : arbiter
    int unsigned idx;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  assign out_empty = !src_rdy_q || TX_MVB_DST_RDY;

  // A full FIFO still accepts a word when it is popped in the same cycle.
  always_comb begin : push_pop
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pop[c]  = out_empty && found && (pick == CH_W'(c));
      push[c] = cand[c] && (!full[c] || pop[c]);
    end
  end

  always_comb begin : out_next
    logic [WW-1:0] word;
    word      = mem_q[pick][rd_ptr_q[pick][AW-1:0]];
    src_rdy_d = src_rdy_q;
    data_d    = data_q;
    vld_d     = vld_q;
    chan_d    = chan_q;
    rr_d      = rr_q;
    if (out_empty) begin
      src_rdy_d = found;
      if (found) begin
        data_d = word[REGIONS-1:0];
        vld_d  = word[WW-1:REGIONS];
        chan_d = pick;
        rr_d   = (32'(pick) == CHANNELS - 1) ? '0 : pick + 1'b1;
      end
    end
  end

  // Clear replaces the old value with this cycle's increment.
  always_comb begin : counters
    logic [PW-1:0]        pc;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] base;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pc = '0;
      for (int unsigned r = 0; r < REGIONS; r++)
        pc = pc + PW'(RX_MVB_DATA[c*REGIONS + r] & RX_MVB_VLD[c*REGIONS + r] & cand[c]);
      base      = clr[c] ? '0 : disc_q[c];
      sum       = {1'b0, base} + (CNT_WIDTH+1)'(pc);
      disc_d[c] = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      base      = clr[c] ? '0 : drop_q[c];
      sum       = {1'b0, base} + (CNT_WIDTH+1)'(cand[c] && !push[c]);
      drop_d[c] = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        disc_q[c]   <= '0;
        drop_q[c]   <= '0;
      end
      src_rdy_q <= 1'b0;
      data_q    <= '0;
      vld_q     <= '0;
      chan_q    <= '0;
      rr_q      <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (push[c]) begin
          mem_q[c][wr_ptr_q[c][AW-1:0]] <= {RX_MVB_VLD[c*REGIONS +: REGIONS],
                                            RX_MVB_DATA[c*REGIONS +: REGIONS]};
          wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        end
        if (pop[c]) rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        disc_q[c] <= disc_d[c];
        drop_q[c] <= drop_d[c];
      end
      src_rdy_q <= src_rdy_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      chan_q    <= chan_d;
      rr_q      <= rr_d;
    end
  end

  assign TX_MVB_SRC_RDY = src_rdy_q;
  assign TX_MVB_DATA    = data_q;
  assign TX_MVB_VLD     = vld_q;
  assign TX_MVB_CHANNEL = chan_q;

  always_comb begin
    CNT_DISCARDED = '0;
    CNT_DROPPED   = '0;
    if (32'(CNT_SEL) < CHANNELS) begin
      CNT_DISCARDED = disc_q[CNT_SEL];
      CNT_DROPPED   = drop_q[CNT_SEL];
    end
  end

endmodule

// File: tb/tb_rx_discard_mvb_merge.sv
// Directed bench for rx_discard_mvb_merge: arbitration, overflow, counters, reset.
module tb_rx_discard_mvb_merge;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] rx_data, rx_vld;
  logic [3:0] rx_rdy;
  logic [1:0] tx_data, tx_vld, tx_ch, cnt_sel;
  logic       tx_rdy, dst_rdy, cnt_clr;
  logic [3:0] cnt_disc, cnt_drop;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 CLK = ~CLK;

  rx_discard_mvb_merge #(
    .CHANNELS(4), .REGIONS(2), .FIFO_DEPTH(16), .CNT_WIDTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_MVB_DATA(rx_data), .RX_MVB_VLD(rx_vld), .RX_MVB_SRC_RDY(rx_rdy),
    .TX_MVB_DATA(tx_data), .TX_MVB_VLD(tx_vld), .TX_MVB_CHANNEL(tx_ch),
    .TX_MVB_SRC_RDY(tx_rdy), .TX_MVB_DST_RDY(dst_rdy),
    .CNT_SEL(cnt_sel), .CNT_CLR(cnt_clr),
    .CNT_DISCARDED(cnt_disc), .CNT_DROPPED(cnt_drop)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    rx_data = '0;
    rx_vld  = '0;
    rx_rdy  = '0;
    cnt_clr = 1'b0;
  endtask

  task automatic set_word(input int c, input logic [1:0] d, input logic [1:0] v);
    rx_data[c*2 +: 2] = d;
    rx_vld[c*2 +: 2]  = v;
    rx_rdy[c]         = 1'b1;
  endtask

  task automatic do_reset();
    clear_in();
    dst_rdy = 1'b0;
    cnt_sel = '0;
    RESET   = 1'b1;
    tick();
    tick();
    RESET   = 1'b0;
  endtask

  function automatic logic [1:0] ovf_vld(input int i);
    return 2'((i % 3) + 1);
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== 7'b0)
      $display("FAIL reset_tx got %b exp 0000000", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      checks++;
      if ({cnt_disc, cnt_drop} !== 8'h00)
        $display("FAIL reset_cnt ch%0d got %h exp 00", c, {cnt_disc, cnt_drop});
      else passes++;
    end
  endtask

  task automatic test_single();
    do_reset();
    set_word(2, 2'b01, 2'b11);
    set_word(0, 2'b11, 2'b00);
    tick();
    clear_in();
    checks++;
    if (tx_rdy !== 1'b0) $display("FAIL single_latency got %b exp 0", tx_rdy);
    else passes++;
    cnt_sel = 2'd2;
    #1;
    checks++;
    if ({cnt_disc, cnt_drop} !== {4'd1, 4'd0})
      $display("FAIL single_cnt got %h exp 10", {cnt_disc, cnt_drop});
    else passes++;
    cnt_sel = 2'd0;
    #1;
    checks++;
    if (cnt_disc !== 4'd0) $display("FAIL zero_vld_cnt got %0d exp 0", cnt_disc);
    else passes++;
    tick();
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd2, 2'b01, 2'b11})
      $display("FAIL single_tx got %b exp 1100111", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    dst_rdy = 1'b1;
    tick();
    checks++;
    if (tx_rdy !== 1'b0) $display("FAIL single_idle got %b exp 0", tx_rdy);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [1:0] d [4];
    logic [1:0] v [4];
    logic [3:0] ed [4];
    d = '{2'b11, 2'b01, 2'b10, 2'b11};
    v = '{2'b01, 2'b10, 2'b11, 2'b11};
    ed = '{4'd1, 4'd0, 4'd1, 4'd2};
    do_reset();
    dst_rdy = 1'b1;
    for (int c = 0; c < 4; c++) set_word(c, d[c], v[c]);
    tick();
    clear_in();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'(c), d[c], v[c]})
        $display("FAIL rr_order step%0d got %b exp %b", c,
                 {tx_rdy, tx_ch, tx_data, tx_vld}, {1'b1, 2'(c), d[c], v[c]});
      else passes++;
    end
    tick();
    checks++;
    if (tx_rdy !== 1'b0) $display("FAIL rr_idle got %b exp 0", tx_rdy);
    else passes++;
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      checks++;
      if (cnt_disc !== ed[c]) $display("FAIL rr_disc ch%0d got %0d exp %0d", c, cnt_disc, ed[c]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cnt_sel = 2'd0;
    for (int i = 0; i < 20; i++) begin
      clear_in();
      set_word(0, 2'b00, ovf_vld(i));
      tick();
      if (i >= 1) begin
        checks++;
        if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd0, 2'b00, ovf_vld(0)})
          $display("FAIL ovf_hold cyc%0d got %b exp %b", i,
                   {tx_rdy, tx_ch, tx_data, tx_vld}, {1'b1, 2'd0, 2'b00, ovf_vld(0)});
        else passes++;
      end
    end
    clear_in();
    checks++;
    if (cnt_drop !== 4'd3) $display("FAIL ovf_dropped got %0d exp 3", cnt_drop);
    else passes++;
    // Full FIFO: push coincides with pop, so it must be accepted.
    dst_rdy = 1'b1;
    set_word(0, 2'b10, 2'b11);
    tick();
    clear_in();
    checks++;
    if (cnt_drop !== 4'd3) $display("FAIL full_pop_drop got %0d exp 3", cnt_drop);
    else passes++;
    checks++;
    if (cnt_disc !== 4'd1) $display("FAIL full_pop_disc got %0d exp 1", cnt_disc);
    else passes++;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) tick();
      checks++;
      if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd0, 2'b00, ovf_vld(i)})
        $display("FAIL ovf_drain w%0d got %b exp %b", i,
                 {tx_rdy, tx_ch, tx_data, tx_vld}, {1'b1, 2'd0, 2'b00, ovf_vld(i)});
      else passes++;
    end
    tick();
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd0, 2'b10, 2'b11})
      $display("FAIL full_pop_word got %b exp 1001011", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    tick();
    checks++;
    if (tx_rdy !== 1'b0) $display("FAIL ovf_idle got %b exp 0", tx_rdy);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    dst_rdy = 1'b1;
    cnt_sel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      set_word(1, 2'b11, 2'b11);
      tick();
      if (i == 6) begin
        checks++;
        if (cnt_disc !== 4'd14) $display("FAIL sat_pre got %0d exp 14", cnt_disc);
        else passes++;
      end
    end
    clear_in();
    checks++;
    if (cnt_disc !== 4'd15) $display("FAIL sat_max got %0d exp 15", cnt_disc);
    else passes++;
    checks++;
    if (cnt_drop !== 4'd0) $display("FAIL sat_drop got %0d exp 0", cnt_drop);
    else passes++;
    set_word(1, 2'b11, 2'b11);
    cnt_clr = 1'b1;
    tick();
    clear_in();
    checks++;
    if (cnt_disc !== 4'd2) $display("FAIL clr_inc got %0d exp 2", cnt_disc);
    else passes++;
    cnt_clr = 1'b1;
    tick();
    clear_in();
    checks++;
    if (cnt_disc !== 4'd0) $display("FAIL clr_zero got %0d exp 0", cnt_disc);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_word(1, 2'b00, 2'b01);
    for (int i = 0; i < 5; i++) begin
      set_word(3, 2'b01, 2'b11);
      tick();
      clear_in();
    end
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd1, 2'b00, 2'b01})
      $display("FAIL mid_pre got %b exp 1010001", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== 7'b0)
      $display("FAIL mid_reset_tx got %b exp 0000000", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    cnt_sel = 2'd3;
    #1;
    checks++;
    if (cnt_disc !== 4'd0) $display("FAIL mid_reset_cnt got %0d exp 0", cnt_disc);
    else passes++;
    dst_rdy = 1'b1;
    set_word(0, 2'b00, 2'b10);
    set_word(3, 2'b10, 2'b10);
    tick();
    clear_in();
    tick();
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd0, 2'b00, 2'b10})
      $display("FAIL mid_post0 got %b exp 1000010", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    tick();
    checks++;
    if ({tx_rdy, tx_ch, tx_data, tx_vld} !== {1'b1, 2'd3, 2'b10, 2'b10})
      $display("FAIL mid_post3 got %b exp 1111010", {tx_rdy, tx_ch, tx_data, tx_vld});
    else passes++;
    tick();
    checks++;
    if (tx_rdy !== 1'b0) $display("FAIL mid_stale got %b exp 0", tx_rdy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rx_discard_mvb_merge.md
Name: rx_discard_mvb_merge

Overview:
- Collects the per-channel RX MAC Lite discard MVB streams (one per Ethernet channel) and merges them into one MVB stream tagged with a channel ID.
- Sits next to the network module RX path. Source streams cannot be back-pressured, so each channel has a word FIFO with overflow accounting.
- Keeps saturating per-channel discard and drop counters, read through a select/readout port.

Parameters:
- CHANNELS, 4, number of input discard streams (1..16)
- REGIONS, 2, MVB items per word (one discard bit per item)
- FIFO_DEPTH, 16, words per channel FIFO; power of two, >=2
- CNT_WIDTH, 32, width of each statistics counter

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- RX_MVB_DATA  in  CHANNELS*REGIONS  discard flag per item; channel c occupies bits [c*REGIONS +: REGIONS]
- RX_MVB_VLD  in  CHANNELS*REGIONS  item valid, same layout
- RX_MVB_SRC_RDY  in  CHANNELS  word present on channel c
- TX_MVB_DATA  out  REGIONS  discard flags of the selected word
- TX_MVB_VLD  out  REGIONS  item valids of the selected word
- TX_MVB_CHANNEL  out  max(1,clog2(CHANNELS))  source channel of the word
- TX_MVB_SRC_RDY  out  1  output word valid
- TX_MVB_DST_RDY  in  1  consumer ready
- CNT_SEL  in  max(1,clog2(CHANNELS))  channel whose counters are shown
- CNT_CLR  in  1  clear both counters of channel CNT_SEL
- CNT_DISCARDED  out  CNT_WIDTH  discarded items counted for CNT_SEL
- CNT_DROPPED  out  CNT_WIDTH  FIFO-overflow dropped words for CNT_SEL

Behaviour:
- The block has one clock domain and no back-pressure toward any RX channel.

Reset:
- All FIFOs are emptied and all counters are 0.
- The round-robin pointer is set to 0.
- TX_MVB_SRC_RDY = 0; TX_MVB_DATA, TX_MVB_VLD and TX_MVB_CHANNEL = 0.
- Reset asserted mid-operation discards all buffered words and restarts the block; the outputs obey the reset values in the next cycle.

Input acceptance, per channel c, each cycle:
- A word is a candidate when RX_MVB_SRC_RDY[c]=1 and its VLD slice is non-zero.
- A candidate word with an all-zero VLD slice is ignored: it is not stored and not counted.
- A candidate is stored if the FIFO is not full, or if it is full and a pop from the same FIFO occurs in the same cycle.
- Otherwise the word is dropped and the channel's drop counter increments by 1.
- The discard counter adds popcount(DATA & VLD) of every candidate word, whether stored or dropped.

Counters:
- Both counters saturate at 2^CNT_WIDTH-1 and never wrap.
- CNT_CLR for channel CNT_SEL takes priority over that cycle's state: new value = that cycle's increment only, not 0.
- CNT_DISCARDED and CNT_DROPPED are a combinational mux of the registered counters by CNT_SEL.
- CNT_SEL >= CHANNELS reads 0, and CNT_CLR with such a selection has no effect.

Output stage (registered):
- Output register is "empty" when TX_MVB_SRC_RDY=0, or when TX_MVB_SRC_RDY=1 and TX_MVB_DST_RDY=1 this cycle.
- When the register is empty, the round-robin arbiter picks the first non-empty FIFO at index >= pointer, wrapping modulo CHANNELS.
- The chosen FIFO is popped and its word is loaded into the register. The pointer becomes (chosen+1) mod CHANNELS.
- If no FIFO is non-empty, TX_MVB_SRC_RDY goes to 0.
- While TX_MVB_SRC_RDY=1 and TX_MVB_DST_RDY=0, all TX outputs hold stable.
- Latency: a word stored in cycle N appears on TX no earlier than cycle N+1.
- Sustained throughput is one word per cycle.

Ordering:
- Order is preserved within a channel.
- Fairness across channels is round-robin.

FIFO:
- Circular buffer with clog2(FIFO_DEPTH)-bit pointers plus a wrap bit. Full/empty are decided by comparing the pointers and wrap bit.
- Occupancy may reach exactly FIFO_DEPTH.

Test Plan:
- Reset, then one word on ch2 (DATA=2'b01, VLD=2'b11) -> next cycle TX_MVB_SRC_RDY=1, CHANNEL=2, DATA=01, VLD=11. CNT_SEL=2 reads DISCARDED=1, DROPPED=0.
- All 4 channels push one word in the same cycle, DST_RDY=1 -> output channel order 0,1,2,3 on consecutive cycles, then SRC_RDY=0.
- DST_RDY=0, ch0 pushes 20 words (FIFO_DEPTH=16) -> 1 word held in the output register, 16 buffered, DROPPED(ch0)=3. Outputs stay stable throughout.
- FIFO full with DST_RDY=1 and a new word arriving in the same cycle as a pop -> word accepted, DROPPED unchanged.
- CNT_WIDTH=4, ch1 fed 10 words of DATA=VLD=11 -> DISCARDED saturates at 15. CNT_CLR in a cycle with an increment of 2 -> reads 2.
- Mid-stream RESET with 5 words buffered on ch3 -> next cycle SRC_RDY=0 and counters 0; post-reset traffic is output correctly starting from pointer 0.
